freelist: RTL

Physical-register free list for the R10K rename path, the responder to dispatch's destination-register allocation requests. Keeps a one-bit-per-register free bitmap and publishes the number of free registers. Returns one-hot grants to dispatch in the same cycle as the request. Reclaims registers freed at retire, and rebuilds its whole state from the architectural in-use mask on a recovery.

---
 rtl/freelist.sv | 103 ++++++++++
 1 files changed

// File: rtl/freelist.sv
// Physical-register free list: one-bit-per-register free bitmap with same-cycle
// rank-ordered grants, retire-time reclaim and single-cycle recovery rebuild.
`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module freelist #(
    parameter int unsigned N           = `N,
    parameter int unsigned PHYS_REG_SZ = `PHYS_REG_SZ_R10K,
    parameter int unsigned ARCH_REG_SZ = `ARCH_REG_SZ,
    parameter int unsigned PHYS_TAG    = $clog2(PHYS_REG_SZ + 1),
    parameter int unsigned CNT_W       = $clog2(PHYS_REG_SZ + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N-1:0]                        free_alloc_valid,
    output logic [N-1:0][PHYS_REG_SZ-1:0]       granted_regs,
    output logic [CNT_W-1:0]                    free_slots,
    input  logic [N-1:0]                        free_valid,
    input  logic [N-1:0][PHYS_TAG-1:0]          free_tag,
    input  logic                                recover_valid,
    input  logic [PHYS_REG_SZ-1:0]              recover_in_use,
    output logic                                alloc_overflow
);

    localparam int unsigned FREE_AT_RESET = PHYS_REG_SZ - ARCH_REG_SZ;

    logic [PHYS_REG_SZ-1:0] free_map;
    logic [PHYS_REG_SZ-1:0] free_map_nxt;
    logic [PHYS_REG_SZ-1:0] granted_any;
    logic [CNT_W-1:0]       rank [PHYS_REG_SZ];
    logic                   short_c;
    logic [CNT_W-1:0]       count_nxt;

    // Rank of each free register among free registers (0 = lowest index).
    always_comb begin
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int j = 0; j < int'(PHYS_REG_SZ); j++) begin
            rank[j] = cnt;
            if (free_map[j] && j != 0) cnt = cnt + CNT_W'(1);
        end
    end

    // Slot i takes the free register whose rank equals the number of lower requesters.
    always_comb begin
        logic [CNT_W-1:0] req_rank;
        req_rank     = '0;
        granted_regs = '0;
        granted_any  = '0;
        short_c      = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (free_alloc_valid[i]) begin
                for (int j = 1; j < int'(PHYS_REG_SZ); j++) begin
                    if (free_map[j] && rank[j] == req_rank) granted_regs[i][j] = 1'b1;
                end
                if (granted_regs[i] == '0) short_c = 1'b1;
                granted_any = granted_any | granted_regs[i];
                req_rank    = req_rank + CNT_W'(1);
            end
        end
    end

    // Next bitmap: recovery rebuild, otherwise consume grants then reclaim frees.
    always_comb begin
        free_map_nxt = free_map & ~granted_any;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 1; j < int'(PHYS_REG_SZ); j++) begin
                if (free_valid[i] && free_tag[i] == PHYS_TAG'(j)) free_map_nxt[j] = 1'b1;
            end
        end
        if (recover_valid) begin
            free_map_nxt    = ~recover_in_use;
            free_map_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        count_nxt = '0;
        for (int j = 0; j < int'(PHYS_REG_SZ); j++) begin
            count_nxt = count_nxt + CNT_W'(free_map_nxt[j]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            free_map       <= {{FREE_AT_RESET{1'b1}}, {ARCH_REG_SZ{1'b0}}};
            free_slots     <= CNT_W'(FREE_AT_RESET);
            alloc_overflow <= 1'b0;
        end else begin
            free_map   <= free_map_nxt;
            free_slots <= count_nxt;
            if (short_c && !recover_valid) alloc_overflow <= 1'b1;
        end
    end

endmodule
